// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction-fetch front end. It contains the fetch PC generator, an in-order,
// variable-latency instruction-memory request port, and a DEPTH-entry prefetch
// FIFO of {pc, instr} pairs that feeds decode. A redirect flushes the FIFO,
// reloads the fetch PC, and arms a drop counter. The drop counter discards the
// responses that are still in flight from the old path.
//
// Optional feature (compile-time macro FETCH_BYPASS_EN):
//   When defined, a response that arrives while the FIFO is empty and no drops
//   are pending is shown on dec_* in the same cycle. If decode accepts it, the
//   response never enters the FIFO.
//
// Parameters:
//   PC_W      fetch address width
//   INS_W     instruction width
//   DEPTH     FIFO entries and maximum outstanding requests (power of two, >= 2)
//   RESET_PC  fetch PC loaded on reset
//
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   imem_req/addr/gnt     request handshake; addr is the current fetch PC
//   imem_rvalid/rdata     in-order responses
//   redirect/redirect_pc  flush and restart fetch at redirect_pc
//   dec_valid/ready       head-of-queue handshake to decode
//   dec_pc/dec_instr      head entry (show-ahead)
//   fifo_count            FIFO occupancy (debug)
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int              PC_W     = 9,
   parameter int              INS_W    = 32,
   parameter int              DEPTH    = 4,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         imem_req,
   output logic [PC_W-1:0]              imem_addr,
   input  logic                         imem_gnt,
   input  logic                         imem_rvalid,
   input  logic [INS_W-1:0]             imem_rdata,
   input  logic                         redirect,
   input  logic [PC_W-1:0]              redirect_pc,
   output logic                         dec_valid,
   input  logic                         dec_ready,
   output logic [PC_W-1:0]              dec_pc,
   output logic [INS_W-1:0]             dec_instr,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);

   logic [PC_W-1:0]  r_fetch_pc;
   logic [PC_W-1:0]  r_pc_q  [DEPTH];
   logic [INS_W-1:0] r_ins_q [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_drop_cnt;
   logic [PC_W-1:0]  r_tag_q [DEPTH];
   logic [PTR_W-1:0] r_tag_rd;
   logic [PTR_W-1:0] r_tag_wr;

   logic [CNT_W:0]   w_inflight;
   logic             w_credit;
   logic             w_fire;
   logic             w_resp;
   logic             w_keep;
   logic             w_fifo_empty;
   logic             w_head_valid;
   logic             w_bypass;
   logic             w_pop;
   logic             w_push;
   logic [PC_W-1:0]  w_resp_tag;

   // Requests in flight plus entries held can never exceed DEPTH. Because of
   // this, every response that is not dropped always has a free FIFO slot.
   assign w_inflight   = {1'b0, r_outstanding} + {1'b0, r_count};
   assign w_credit     = w_inflight < (CNT_W+1)'(DEPTH);

   assign imem_req     = !reset && !redirect && w_credit;
   assign imem_addr    = r_fetch_pc;
   assign w_fire       = imem_req && imem_gnt;

   // A response with nothing outstanding is a protocol error, so it is ignored.
   assign w_resp       = imem_rvalid && (r_outstanding != '0);
   assign w_resp_tag   = r_tag_q[r_tag_rd];
   assign w_keep       = w_resp && !redirect && (r_drop_cnt == '0);

   assign w_fifo_empty = (r_count == '0);
   assign w_head_valid = !w_fifo_empty && !redirect;

`ifdef FETCH_BYPASS_EN
   assign w_bypass     = w_keep && w_fifo_empty;
`else
   assign w_bypass     = 1'b0;
`endif

   assign dec_valid    = w_head_valid || w_bypass;
   assign dec_pc       = !w_fifo_empty ? r_pc_q[r_rd_ptr]  : (w_bypass ? w_resp_tag : '0);
   assign dec_instr    = !w_fifo_empty ? r_ins_q[r_rd_ptr] : (w_bypass ? imem_rdata : '0);
   assign fifo_count   = r_count;

   assign w_pop        = w_head_valid && dec_ready;
   assign w_push       = w_keep && !(w_bypass && dec_ready);

   // The storage arrays hold no reset state. Validity is tracked only by the
   // counters and pointers.
   always_ff @(posedge clk) begin
      if (w_push && !reset) begin
         r_pc_q[r_wr_ptr]  <= w_resp_tag;
         r_ins_q[r_wr_ptr] <= imem_rdata;
      end
      if (w_fire) begin
         r_tag_q[r_tag_wr] <= r_fetch_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
         r_tag_rd      <= '0;
         r_tag_wr      <= '0;
      end else begin
         r_outstanding <= r_outstanding + CNT_W'(w_fire) - CNT_W'(w_resp);
         if (w_fire) r_tag_wr <= r_tag_wr + PTR_W'(1);
         if (w_resp) r_tag_rd <= r_tag_rd + PTR_W'(1);

         if (redirect) begin
            // The response returning in this cycle is discarded as well. The
            // remaining tags stay queued so that the stale responses can pop them.
            r_fetch_pc <= redirect_pc;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= r_outstanding - CNT_W'(w_resp);
         end else begin
            if (w_fire) r_fetch_pc <= r_fetch_pc + PC_W'(4);
            if (w_resp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
         end
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int              PC_W     = 9;
   localparam int              INS_W    = 32;
   localparam int              DEPTH    = 4;
   localparam logic [PC_W-1:0] RESET_PC = '0;
   localparam int              CNT_W    = $clog2(DEPTH + 1);
`ifdef FETCH_BYPASS_EN
   localparam int              FIRST_LAT = 1;
`else
   localparam int              FIRST_LAT = 2;
`endif

   logic              clk;
   logic              reset;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [INS_W-1:0]  imem_rdata;
   logic              redirect;
   logic [PC_W-1:0]   redirect_pc;
   logic              dec_valid;
   logic              dec_ready;
   logic [PC_W-1:0]   dec_pc;
   logic [INS_W-1:0]  dec_instr;
   logic [CNT_W-1:0]  fifo_count;

   fetch_queue #(.PC_W(PC_W), .INS_W(INS_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_pc(dec_pc), .dec_instr(dec_instr), .fifo_count(fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: granted requests wait in a queue until their due cycle.
   // Responses return in order.
   typedef struct {
      logic [PC_W-1:0] addr;
      int              due;
   } req_t;
   req_t mq[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_due = 0;
   int lat_min  = 1;
   int lat_max  = 1;
   int delivered = 0;

   // Reference model of the architectural streams: decode must see PCs that
   // are contiguous from the last restart point, and requests must go out in
   // that order too.
   logic [PC_W-1:0] exp_pc    = RESET_PC;
   logic [PC_W-1:0] exp_fetch = RESET_PC;
   logic            s_hs;
   logic            s_fire;

   function automatic logic [INS_W-1:0] mem_data(input logic [PC_W-1:0] a);
      logic [31:0] x;
      x = 32'h9E37_79B1 * (32'(a) + 32'd1);
      return INS_W'(x ^ 32'h00C0_FFEE);
   endfunction

   task automatic drive(input logic rst, input logic redir, input logic [PC_W-1:0] rpc,
                        input logic rdy, input logic gnt);
      reset       = rst;
      redirect    = redir;
      redirect_pc = rpc;
      dec_ready   = rdy;
      imem_gnt    = gnt;
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_data(mq[0].addr);
      end else begin
         imem_rvalid = 1'b0;
         imem_rdata  = INS_W'($urandom);
      end
      #2;
      s_hs   = dec_valid && dec_ready && !rst;
      s_fire = imem_req && imem_gnt;
   endtask

   task automatic advance();
      req_t r;
      int   lat;
      if (reset) begin
         mq.delete();
         exp_pc    = RESET_PC;
         exp_fetch = RESET_PC;
         last_due  = cyc;
      end else begin
         if (imem_rvalid) void'(mq.pop_front());
         if (redirect) begin
            exp_pc    = redirect_pc;
            exp_fetch = redirect_pc;
         end else begin
            if (s_hs) begin
               exp_pc    = exp_pc + PC_W'(4);
               delivered = delivered + 1;
            end
            if (s_fire) begin
               lat = $urandom_range(lat_max, lat_min);
               r.addr = imem_addr;
               r.due  = cyc + lat;
               if (r.due <= last_due) r.due = last_due + 1;
               last_due = r.due;
               mq.push_back(r);
               exp_fetch = exp_fetch + PC_W'(4);
            end
         end
      end
      @(posedge clk);
      #1;
      cyc = cyc + 1;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
         advance();
      end
   endtask

   task automatic test_reset();
      do_reset(1);
      drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_imem_req got=%0b exp=0", imem_req); end
      checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL reset_imem_addr got=%0h exp=%0h", imem_addr, RESET_PC); end
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL reset_dec_valid got=%0b exp=0", dec_valid); end
      checks++; if (dec_pc !== '0) begin failures++; $display("FAIL reset_dec_pc got=%0h exp=0", dec_pc); end
      checks++; if (dec_instr !== '0) begin failures++; $display("FAIL reset_dec_instr got=%0h exp=0", dec_instr); end
      checks++; if (fifo_count !== '0) begin failures++; $display("FAIL reset_fifo_count got=%0d exp=0", fifo_count); end
      advance();
   endtask

   task automatic test_stream();
      int d0;
      do_reset(2);
      lat_min = 1; lat_max = 1;
      d0 = delivered;
      for (int k = 0; k < 25; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         checks++;
         if (dec_valid !== (k >= FIRST_LAT)) begin
            failures++; $display("FAIL stream_valid k=%0d got=%0b exp=%0b", k, dec_valid, (k >= FIRST_LAT));
         end
         if (s_fire) begin
            checks++; if (imem_addr !== exp_fetch) begin failures++; $display("FAIL stream_addr got=%0h exp=%0h", imem_addr, exp_fetch); end
         end
         if (s_hs) begin
            checks++; if (dec_pc !== exp_pc) begin failures++; $display("FAIL stream_pc got=%0h exp=%0h", dec_pc, exp_pc); end
            checks++; if (dec_instr !== mem_data(exp_pc)) begin failures++; $display("FAIL stream_instr got=%0h exp=%0h", dec_instr, mem_data(exp_pc)); end
         end
         advance();
      end
      checks++;
      if (delivered - d0 != 25 - FIRST_LAT) begin
         failures++; $display("FAIL stream_count got=%0d exp=%0d", delivered - d0, 25 - FIRST_LAT);
      end
   endtask

   task automatic test_stall();
      do_reset(2);
      lat_min = 1; lat_max = 1;
      for (int k = 0; k < 10; k++) begin
         drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
         if (k == 9) begin
            checks++; if (fifo_count !== CNT_W'(DEPTH)) begin failures++; $display("FAIL stall_count got=%0d exp=%0d", fifo_count, DEPTH); end
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req got=%0b exp=0", imem_req); end
            checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%0b exp=1", dec_valid); end
         end
         advance();
      end
      for (int k = 0; k < 12; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         checks++; if (dec_valid !== 1'b1) begin failures++; $display("FAIL release_gap k=%0d got=%0b exp=1", k, dec_valid); end
         checks++; if (dec_pc !== PC_W'(4 * k)) begin failures++; $display("FAIL release_pc k=%0d got=%0h exp=%0h", k, dec_pc, PC_W'(4 * k)); end
         checks++; if (dec_instr !== mem_data(PC_W'(4 * k))) begin failures++; $display("FAIL release_instr k=%0d got=%0h exp=%0h", k, dec_instr, mem_data(PC_W'(4 * k))); end
         advance();
      end
   endtask

   task automatic test_redirect_drop();
      logic [PC_W-1:0] got[2];
      int n;
      do_reset(2);
      lat_min = 3; lat_max = 3;
      for (int k = 0; k < 20 && mq.size() != 3; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         advance();
      end
      checks++; if (mq.size() != 3) begin failures++; $display("FAIL drop_setup_timeout got=%0d exp=3", mq.size()); end
      drive(1'b0, 1'b1, PC_W'(9'h040), 1'b1, 1'b1);
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL drop_redir_valid got=%0b exp=0", dec_valid); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL drop_redir_req got=%0b exp=0", imem_req); end
      advance();
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL drop_new_req got=%0b exp=1", imem_req); end
      checks++; if (imem_addr !== PC_W'(9'h040)) begin failures++; $display("FAIL drop_new_addr got=%0h exp=40", imem_addr); end
      advance();
      n = 0;
      for (int k = 0; k < 30 && n < 2; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         if (s_hs) begin
            got[n] = dec_pc;
            n++;
            checks++; if (dec_instr !== mem_data(exp_pc)) begin failures++; $display("FAIL drop_instr got=%0h exp=%0h", dec_instr, mem_data(exp_pc)); end
         end
         advance();
      end
      checks++; if (n != 2) begin failures++; $display("FAIL drop_timeout got=%0d exp=2", n); end
      else begin
         checks++; if (got[0] !== PC_W'(9'h040)) begin failures++; $display("FAIL drop_pc0 got=%0h exp=40", got[0]); end
         checks++; if (got[1] !== PC_W'(9'h044)) begin failures++; $display("FAIL drop_pc1 got=%0h exp=44", got[1]); end
      end
   endtask

   task automatic test_redirect_rvalid();
      int n;
      do_reset(2);
      lat_min = 1; lat_max = 1;
      for (int k = 0; k < 6; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         advance();
      end
      drive(1'b0, 1'b1, PC_W'(9'h080), 1'b1, 1'b1);
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rv_redir_valid got=%0b exp=0 rvalid=%0b", dec_valid, imem_rvalid); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rv_redir_req got=%0b exp=0", imem_req); end
      advance();
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
      checks++; if (fifo_count !== '0) begin failures++; $display("FAIL rv_flush_count got=%0d exp=0", fifo_count); end
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rv_flush_valid got=%0b exp=0", dec_valid); end
      checks++; if (imem_addr !== PC_W'(9'h080)) begin failures++; $display("FAIL rv_new_addr got=%0h exp=80", imem_addr); end
      advance();
      n = 0;
      for (int k = 0; k < 10 && n < 1; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         if (s_hs) begin
            n++;
            checks++; if (dec_pc !== PC_W'(9'h080)) begin failures++; $display("FAIL rv_first_pc got=%0h exp=80", dec_pc); end
            checks++; if (dec_instr !== mem_data(PC_W'(9'h080))) begin failures++; $display("FAIL rv_first_instr got=%0h exp=%0h", dec_instr, mem_data(PC_W'(9'h080))); end
         end
         advance();
      end
      checks++; if (n != 1) begin failures++; $display("FAIL rv_timeout got=%0d exp=1", n); end
   endtask

   task automatic test_wrap();
      logic [PC_W-1:0] got[3];
      logic [PC_W-1:0] want[3];
      int n;
      want[0] = PC_W'(9'h1FC); want[1] = PC_W'(9'h000); want[2] = PC_W'(9'h004);
      do_reset(2);
      lat_min = 1; lat_max = 1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         advance();
      end
      drive(1'b0, 1'b1, PC_W'(9'h1FC), 1'b1, 1'b1);
      advance();
      n = 0;
      for (int k = 0; k < 15 && n < 3; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         if (s_hs) begin got[n] = dec_pc; n++; end
         advance();
      end
      checks++; if (n != 3) begin failures++; $display("FAIL wrap_timeout got=%0d exp=3", n); end
      else begin
         for (int i = 0; i < 3; i++) begin
            checks++; if (got[i] !== want[i]) begin failures++; $display("FAIL wrap_pc%0d got=%0h exp=%0h", i, got[i], want[i]); end
         end
      end
   endtask

   task automatic test_reset_midstream();
      int n;
      do_reset(2);
      lat_min = 1; lat_max = 2;
      for (int k = 0; k < 12; k++) begin
         drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
         advance();
      end
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1);
      checks++; if (fifo_count !== CNT_W'(DEPTH)) begin failures++; $display("FAIL mid_full got=%0d exp=%0d", fifo_count, DEPTH); end
      advance();
      drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
      advance();
      drive(1'b1, 1'b0, '0, 1'b1, 1'b1);
      checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%0b exp=0", dec_valid); end
      checks++; if (fifo_count !== '0) begin failures++; $display("FAIL mid_count got=%0d exp=0", fifo_count); end
      checks++; if (imem_addr !== RESET_PC) begin failures++; $display("FAIL mid_addr got=%0h exp=%0h", imem_addr, RESET_PC); end
      checks++; if (dec_pc !== '0) begin failures++; $display("FAIL mid_dec_pc got=%0h exp=0", dec_pc); end
      advance();
      drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL mid_restart_req got=%0b exp=1", imem_req); end
      advance();
      n = 0;
      for (int k = 0; k < 12; k++) begin
         drive(1'b0, 1'b0, '0, 1'b1, 1'b1);
         if (s_hs) begin
            checks++; if (dec_pc !== PC_W'(4 * n)) begin failures++; $display("FAIL mid_stream_pc got=%0h exp=%0h", dec_pc, PC_W'(4 * n)); end
            n++;
         end
         advance();
      end
      checks++; if (n < 5) begin failures++; $display("FAIL mid_stream_timeout got=%0d exp>=5", n); end
   endtask

   task automatic test_random();
      int              d0;
      logic            rdy, gnt, rd;
      logic [PC_W-1:0] rpc;
      logic            exp_req;
      do_reset(2);
      lat_min = 1; lat_max = 5;
      d0 = delivered;
      for (int k = 0; k < 1500; k++) begin
         rdy = ($urandom_range(99, 0) < 70);
         gnt = ($urandom_range(99, 0) < 80);
         rd  = ($urandom_range(99, 0) < 4);
         rpc = PC_W'($urandom) & ~PC_W'(3);
         drive(1'b0, rd, rpc, rdy, gnt);
         exp_req = !rd && ((mq.size() + int'(fifo_count)) < DEPTH);
         checks++; if (imem_req !== exp_req) begin failures++; $display("FAIL rnd_req k=%0d got=%0b exp=%0b", k, imem_req, exp_req); end
         checks++; if ((mq.size() + int'(fifo_count)) > DEPTH) begin failures++; $display("FAIL rnd_credit k=%0d got=%0d exp<=%0d", k, mq.size() + int'(fifo_count), DEPTH); end
         if (rd) begin
            checks++; if (dec_valid !== 1'b0) begin failures++; $display("FAIL rnd_redir_valid k=%0d got=%0b exp=0", k, dec_valid); end
         end
`ifndef FETCH_BYPASS_EN
         checks++; if (dec_valid !== (fifo_count != '0 && !rd)) begin failures++; $display("FAIL rnd_valid k=%0d got=%0b exp=%0b", k, dec_valid, (fifo_count != '0 && !rd)); end
`endif
         if (s_fire) begin
            checks++; if (imem_addr !== exp_fetch) begin failures++; $display("FAIL rnd_addr k=%0d got=%0h exp=%0h", k, imem_addr, exp_fetch); end
         end
         if (s_hs) begin
            checks++; if (dec_pc !== exp_pc) begin failures++; $display("FAIL rnd_pc k=%0d got=%0h exp=%0h", k, dec_pc, exp_pc); end
            checks++; if (dec_instr !== mem_data(exp_pc)) begin failures++; $display("FAIL rnd_instr k=%0d got=%0h exp=%0h", k, dec_instr, mem_data(exp_pc)); end
         end
         advance();
      end
      checks++; if (delivered - d0 < 100) begin failures++; $display("FAIL rnd_progress got=%0d exp>=100", delivered - d0); end
   endtask

   initial begin
      reset = 1'b1; redirect = 1'b0; redirect_pc = '0; dec_ready = 1'b0;
      imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_drop();
      test_redirect_rvalid();
      test_wrap();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
